load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, default 16, the number of cycles spent in REQ+WAIT before a bus-timeout error is raised (legal range 2..255).
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  the execute stage presents a memory operation.
REQ-005 req_ready  out  1  the unit accepts the operation this cycle.
REQ-006 is_store  in  1  1 = store, 0 = load.
REQ-007 funct3  in  3  RV32I width/sign code.
REQ-008 addr  in  32  byte address (ALU ADD result, rs1+imm).
REQ-009 store_data  in  32  rs2 value.
REQ-010 rd_idx  in  5  load destination register.
REQ-011 busy  out  1  the unit is not IDLE; used to stall the PC.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rd  out  5  latched rd_idx (0 for stores).
REQ-014 load_data  out  32  the extended load result.
REQ-015 err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout.
REQ-016 mem_req  out  1  memory request.
REQ-017 mem_we  out  1  write enable.
REQ-018 mem_addr  out  32  word address, {addr[31:2],2'b00}.
REQ-019 mem_wstrb  out  4  byte strobes.
REQ-020 mem_wdata  out  32  write data.
REQ-021 mem_gnt  in  1  memory accepts mem_req this cycle.
REQ-022 mem_rvalid  in  1  read data valid.
REQ-023 mem_rdata  in  32  read data.

Function
REQ-024 The FSM SHALL have four states, IDLE, REQ, WAIT and RESP, and req_ready SHALL be 1 only in IDLE.
REQ-025 On req_valid in IDLE, the unit SHALL latch is_store, funct3, addr, store_data and rd_idx, and SHALL classify the operation:
- Legal funct3, loads: 000, 001, 010, 100, 101.
- Legal funct3, stores: 000, 001, 010.
- Illegal funct3 -> go to RESP with err=10.
- Otherwise, halfword with addr[0]=1 or word with addr[1:0]!=0 -> go to RESP with err=01.
- Otherwise -> go to REQ.
REQ-026 Illegal funct3 SHALL take priority over misalignment, and erroring operations SHALL never assert mem_req.
REQ-027 In REQ, mem_req SHALL be 1 and mem_we, mem_addr, mem_wstrb and mem_wdata SHALL be held stable until mem_gnt.
REQ-028 On mem_gnt in REQ, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-029 In WAIT, on mem_rvalid the unit SHALL capture the extracted data and go to RESP.
REQ-030 mem_rvalid outside WAIT SHALL be ignored.
REQ-031 In RESP, resp_valid SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-032 resp_rd, load_data and err SHALL be held until the next RESP.
REQ-033 Store strobes and data:
- SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated x4.
- SH: wstrb = addr[1] ? 1100 : 0011; wdata = halfword replicated x2.
- SW: wstrb = 1111; wdata = store_data.
REQ-034 When mem_we=0, mem_wstrb SHALL be 0000.
REQ-035 Load extraction: lane = mem_rdata >> (8*addr[1:0]).
- LB/LH SHALL sign-extend bit 7 / bit 15 of lane.
- LBU/LHU SHALL zero-extend.
- LW SHALL pass mem_rdata unchanged.
REQ-036 A timeout counter SHALL clear on entry to REQ and increment in each REQ/WAIT cycle; when it reaches TIMEOUT-1 without the awaited mem_gnt or mem_rvalid, the FSM SHALL go to RESP with err=11 and load_data=0.
REQ-037 A grant or rvalid arriving in the same cycle as the timeout limit SHALL win over the timeout (err=00).
REQ-038 Latency: accept at cycle T, mem_req at T+1. A store granted at T+1 completes with resp_valid at T+2. A load with rvalid at T+2 completes with resp_valid at T+3. An error completes with resp_valid at T+1.
REQ-039 busy SHALL equal (state != IDLE), a combinational decode.
REQ-040 The unit SHALL accept a new request in the cycle immediately after RESP, and there SHALL be no back-to-back acceptance while busy.

Reset
REQ-041 Asserting rst_n=0 SHALL immediately force IDLE, with mem_req, mem_we, resp_valid and busy at 0.
REQ-042 Under rst_n=0, mem_wstrb and err SHALL be 0, load_data, mem_addr, mem_wdata and resp_rd SHALL be 0, and the timeout counter SHALL be 0.
REQ-043 A reset during REQ/WAIT SHALL abandon the transaction with no resp_valid, and a later mem_rvalid SHALL be ignored.

Verification
REQ-044 Load sign-extension: LB addr=0x103, rdata=0x80FF_0000 with rvalid one cycle after grant -> resp_valid at T+3, load_data=0xFFFF_FF80, err=00; LBU with the same stimulus -> 0x0000_0080.
REQ-045 Store strobes: SH addr=0x202, store_data=0x1234_ABCD, gnt immediate -> mem_addr=0x200, wstrb=1100, wdata=0xABCD_ABCD, resp_valid at T+2, resp_rd=0.
REQ-046 Misaligned and illegal requests: LW addr=0x101 -> resp_valid at T+1, err=01, mem_req never 1; store funct3=011 with addr=0x101 -> err=10.
REQ-047 Timeout with TIMEOUT=16: a load with mem_gnt held low -> resp_valid 16 cycles after entering REQ, err=11, load_data=0; a second run with gnt on the final cycle -> no error.
REQ-048 Reset mid-operation: a load in WAIT, rst_n pulsed low, then mem_rvalid -> no resp_valid, and busy=0 immediately on reset assertion.
REQ-049 Back-to-back operations: SW then LW to address 0x40 with req_valid held high -> second accept exactly one cycle after the first resp_valid, load_data returns the stored word from the memory model.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | load_store_unit_if : request/response and memory-bus bundle of the LSU  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [4:0]  rd_idx;
   logic        busy;
   logic        resp_valid;
   logic [4:0]  resp_rd;
   logic [31:0] load_data;
   logic [1:0]  err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, is_store, funct3, addr, store_data, rd_idx,
             mem_gnt, mem_rvalid, mem_rdata,
      output req_ready, busy, resp_valid, resp_rd, load_data, err,
             mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
   );

   modport master (
      output req_valid, is_store, funct3, addr, store_data, rd_idx,
             mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready, busy, resp_valid, resp_rd, load_data, err,
             mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | load_store_unit : RV32I load/store unit with a req/gnt/rvalid memory bus |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   load_store_unit_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [7:0] c_LIMIT = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_is_store;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [4:0]  r_rd;
   logic [7:0]  r_cnt;
   logic [4:0]  r_resp_rd;
   logic [31:0] r_load_data;
   logic [1:0]  r_err;

   logic        w_legal;
   logic        w_misaligned;
   logic        w_accept;
   logic        w_to_resp;
   logic [1:0]  w_err;
   logic [31:0] w_data;
   logic [4:0]  w_rd;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;

   // Classification of the incoming operation; illegal funct3 outranks misalignment.
   always_comb begin
      w_legal = 1'b0;
      case (bus.funct3)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = !bus.is_store;
         default:                w_legal = 1'b0;
      endcase
      w_misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
   end

   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = bus.store_data;
      if (bus.is_store) begin
         case (bus.funct3[1:0])
            2'b00: begin
               w_wstrb = 4'b0001 << bus.addr[1:0];
               w_wdata = {4{bus.store_data[7:0]}};
            end
            2'b01: begin
               w_wstrb = bus.addr[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{bus.store_data[15:0]}};
            end
            default: w_wstrb = 4'b1111;
         endcase
      end
   end

   // Lane selection: only aligned halfwords ever reach the bus, so addr[1] picks the half.
   always_comb begin
      case (r_addr[1:0])
         2'b00:   w_byte = bus.mem_rdata[7:0];
         2'b01:   w_byte = bus.mem_rdata[15:8];
         2'b10:   w_byte = bus.mem_rdata[23:16];
         default: w_byte = bus.mem_rdata[31:24];
      endcase
      w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b100:  w_ext = {24'd0, w_byte};
         3'b101:  w_ext = {16'd0, w_half};
         default: w_ext = bus.mem_rdata;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_to_resp   = 1'b0;
      w_err       = 2'b00;
      w_data      = 32'd0;
      w_rd        = r_is_store ? 5'd0 : r_rd;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               w_accept = 1'b1;
               w_rd     = bus.is_store ? 5'd0 : bus.rd_idx;
               if (!w_legal) begin
                  w_state_nxt = S_RESP;
                  w_to_resp   = 1'b1;
                  w_err       = 2'b10;
               end else if (w_misaligned) begin
                  w_state_nxt = S_RESP;
                  w_to_resp   = 1'b1;
                  w_err       = 2'b01;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (bus.mem_gnt) begin
               if (r_is_store) begin
                  w_state_nxt = S_RESP;
                  w_to_resp   = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else if (r_cnt >= c_LIMIT) begin
               w_state_nxt = S_RESP;
               w_to_resp   = 1'b1;
               w_err       = 2'b11;
            end
         end
         S_WAIT: begin
            // A late grant can push the count past the limit; data arriving still wins.
            if (bus.mem_rvalid) begin
               w_state_nxt = S_RESP;
               w_to_resp   = 1'b1;
               w_data      = w_ext;
            end else if (r_cnt >= c_LIMIT) begin
               w_state_nxt = S_RESP;
               w_to_resp   = 1'b1;
               w_err       = 2'b11;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_store  <= 1'b0;
         r_funct3    <= 3'd0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_wstrb     <= 4'd0;
         r_rd        <= 5'd0;
         r_cnt       <= 8'd0;
         r_resp_rd   <= 5'd0;
         r_load_data <= 32'd0;
         r_err       <= 2'b00;
      end else begin
         if (w_accept) begin
            r_is_store <= bus.is_store;
            r_funct3   <= bus.funct3;
            r_addr     <= bus.addr;
            r_wdata    <= w_wdata;
            r_wstrb    <= w_wstrb;
            r_rd       <= bus.rd_idx;
         end
         if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + 8'd1;
         end else begin
            r_cnt <= 8'd0;
         end
         if (w_to_resp) begin
            r_err       <= w_err;
            r_load_data <= w_data;
            r_resp_rd   <= w_rd;
         end
      end
   end

   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.resp_valid = (r_state == S_RESP);
   assign bus.mem_req    = (r_state == S_REQ);
   assign bus.mem_we     = (r_state == S_REQ) && r_is_store;
   assign bus.mem_addr   = {r_addr[31:2], 2'b00};
   assign bus.mem_wstrb  = bus.mem_we ? r_wstrb : 4'b0000;
   assign bus.mem_wdata  = r_wdata;
   assign bus.resp_rd    = r_resp_rd;
   assign bus.load_data  = r_load_data;
   assign bus.err        = r_err;

endmodule
`default_nettype wire
